// File: rtl/pkt_data_pkg.sv
// Shared definitions for the PN packet data source.
// Holds the mode codes, the FSM state encoding, the LFSR reset seed and small helpers.
// No ports: this is a package imported by pkt_data_src and its bench.
package pkt_data_pkg;

  // MODE_CTRL encodings. Any other value means the source is switched off.
  localparam logic [3:0] MODE_BPSK = 4'b0001;
  localparam logic [3:0] MODE_QPSK = 4'b0010;
  localparam logic [3:0] MODE_MIX  = 4'b0100;

  // Packet FSM states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_SENT = 2'd3
  } pkt_state_t;

  // LFSR seed: all ones, sliced down to the configured register length.
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;

  function automatic logic mode_defined(input logic [3:0] mode);
    return (mode == MODE_BPSK) || (mode == MODE_QPSK) || (mode == MODE_MIX);
  endfunction

  // A zero-length request still produces a one-bit payload; oversize requests saturate.
  function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] max_len);
    logic [15:0] res;
    res = len;
    if (len == 16'd0) begin
      res = 16'd1;
    end else if (len > max_len) begin
      res = max_len;
    end
    return res;
  endfunction

endpackage

// File: rtl/pn_lfsr_step.sv
// Combinational one- and two-step next state of a Fibonacci PN register.
// Latency: zero (pure combinational). Backpressure: none, the caller decides when to commit.
// Ports: state (current register), next1 (after one shift), next2 (after two shifts).
// The new PN bit of each shift enters at bit 0, so next1[0] is the first output bit
// and next2[0] the second.
module pn_lfsr_step #(
  parameter int          N    = 7,
  parameter logic [15:0] TAPS = 16'h0060
) (
  input  logic [N-1:0] state,
  output logic [N-1:0] next1,
  output logic [N-1:0] next2
);

  // Tap bit i selects stage i+1, i.e. register bit i.
  localparam logic [N-1:0] MASK = TAPS[N-1:0];

  logic fb1;
  logic fb2;

  assign fb1   = ^(state & MASK);
  assign next1 = {state[N-2:0], fb1};
  assign fb2   = ^(next1 & MASK);
  assign next2 = {next1[N-2:0], fb2};

endmodule

// File: rtl/pkt_data_src.sv
// PN-sequence packet source: emits BPSK (1 bit) or QPSK (2 bit) symbols as AXI-stream packets.
// Latency: two enabled cycles from a defined mode (IDLE->LOAD->SEND) to the first valid beat.
// Backpressure: a beat needs clk_enable & tvalid & tready; otherwise all outputs and state hold.
// Ports: clk/rst (sync, active-high), clk_enable symbol strobe, MODE_CTRL/len_cfg configuration,
//        pkt_sent downstream done pulse, data_* AXIS source, payload_length and pkt_count status.
module pkt_data_src
  import pkt_data_pkg::*;
#(
  parameter int          BYTES     = 1,
  parameter int          LFSR_N    = 7,
  parameter logic [15:0] LFSR_TAPS = 16'h0060,
  parameter int          PAD_SYMBS = 4,
  parameter logic [15:0] MAX_LEN   = 16'd2048
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_enable,
  input  logic [3:0]         MODE_CTRL,
  input  logic [15:0]        len_cfg,
  input  logic               pkt_sent,
  output logic [BYTES*8-1:0] data_tdata,
  output logic               data_tvalid,
  input  logic               data_tready,
  output logic               data_tlast,
  output logic               data_tuser,
  output logic [15:0]        payload_length,
  output logic [15:0]        pkt_count
);

  localparam logic [15:0] PAD_W = PAD_SYMBS[15:0];

  pkt_state_t        state_q;
  pkt_state_t        state_d;
  logic              bpsk_q;      // symbol type of the packet being sent
  logic              mix_flag_q;  // MIX alternation, survives across packets
  logic [15:0]       len_q;
  logic [15:0]       nsym_q;
  logic [15:0]       sym_cnt_q;
  logic [15:0]       pkt_cnt_q;
  logic [LFSR_N-1:0] lfsr_q;
  logic [LFSR_N-1:0] lfsr_next1;
  logic [LFSR_N-1:0] lfsr_next2;

  logic              send_vld;
  logic              beat;
  logic              last_sym;
  logic              mode_ok;
  logic              load_bpsk;
  logic [15:0]       len_clamped;
  logic [16:0]       len_p1;
  logic [15:0]       nsym_calc;

  pn_lfsr_step #(
    .N    (LFSR_N),
    .TAPS (LFSR_TAPS)
  ) u_step (
    .state (lfsr_q),
    .next1 (lfsr_next1),
    .next2 (lfsr_next2)
  );

  assign send_vld = (state_q == ST_SEND);
  assign beat     = clk_enable & send_vld & data_tready;
  assign last_sym = (sym_cnt_q == (nsym_q - 16'd1));
  assign mode_ok  = mode_defined(MODE_CTRL);

  // Packet sizing evaluated from the live configuration; only committed in LOAD.
  assign len_clamped = clamp_len(len_cfg, MAX_LEN);
  assign len_p1      = {1'b0, len_clamped} + 17'd1;

  always_comb begin
    load_bpsk = 1'b0;
    case (MODE_CTRL)
      MODE_BPSK: load_bpsk = 1'b1;
      MODE_MIX:  load_bpsk = mix_flag_q;  // flag starts at 0, so MIX opens with QPSK
      default:   load_bpsk = 1'b0;
    endcase
  end

  // QPSK carries two bits per symbol, an odd trailing bit still takes a whole symbol.
  assign nsym_calc = (load_bpsk ? len_clamped : len_p1[16:1]) + PAD_W;

  // Next state and outputs. Outputs depend only on registers, so they cannot change
  // while a beat is stalled.
  always_comb begin
    state_d     = state_q;
    data_tvalid = send_vld;
    data_tlast  = send_vld & last_sym;
    data_tuser  = send_vld & bpsk_q;
    data_tdata  = '0;
    if (send_vld) begin
      data_tdata[0] = lfsr_next1[0];
      data_tdata[1] = ~bpsk_q & lfsr_next2[0];
    end

    case (state_q)
      ST_IDLE: begin
        if (mode_ok) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // The mode may have been withdrawn since IDLE; fall back rather than send garbage.
        state_d = mode_ok ? ST_SEND : ST_IDLE;
      end
      ST_SEND: begin
        if (beat && last_sym) state_d = ST_WAIT_SENT;
      end
      ST_WAIT_SENT: begin
        if (pkt_sent) state_d = mode_ok ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bpsk_q     <= 1'b0;
      mix_flag_q <= 1'b0;
      len_q      <= 16'd0;
      nsym_q     <= 16'd0;
      sym_cnt_q  <= 16'd0;
      pkt_cnt_q  <= 16'd0;
      lfsr_q     <= LFSR_SEED[LFSR_N-1:0];
    end else if (clk_enable) begin
      state_q <= state_d;
      case (state_q)
        ST_LOAD: begin
          if (mode_ok) begin
            len_q     <= len_clamped;
            bpsk_q    <= load_bpsk;
            nsym_q    <= nsym_calc;
            sym_cnt_q <= 16'd0;
            if (MODE_CTRL == MODE_MIX) mix_flag_q <= ~mix_flag_q;
          end
        end
        ST_SEND: begin
          if (beat) begin
            // The LFSR runs continuously across packets so the stream stays contiguous.
            lfsr_q <= bpsk_q ? lfsr_next1 : lfsr_next2;
            if (last_sym) begin
              sym_cnt_q <= 16'd0;
              pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end else begin
              sym_cnt_q <= sym_cnt_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign payload_length = len_q;
  assign pkt_count      = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_data_src.sv
// Directed bench for pkt_data_src: BPSK, QPSK, MIX, stalls, length clamping, mid-packet reset.
// Expected PN bits come from a bench-side x^7+x^6+1 register seeded with all ones.
module tb_pkt_data_src;
  import pkt_data_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_enable = 1'b0;
  logic [3:0]  MODE_CTRL = 4'd0;
  logic [15:0] len_cfg = 16'd0;
  logic        pkt_sent = 1'b0;
  logic [7:0]  data_tdata;
  logic        data_tvalid;
  logic        data_tready = 1'b1;
  logic        data_tlast;
  logic        data_tuser;
  logic [15:0] payload_length;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;

  // Capture results of the most recent collect() call.
  bit   bits_q[$];
  int   nbeats, last_idx, nlast, user_ones, user_zeros, stall_err, hi_err;
  bit   timed_out;
  logic [6:0] model_s;

  always #5 clk = ~clk;

  pkt_data_src dut (
    .clk            (clk),
    .rst            (rst),
    .clk_enable     (clk_enable),
    .MODE_CTRL      (MODE_CTRL),
    .len_cfg        (len_cfg),
    .pkt_sent       (pkt_sent),
    .data_tdata     (data_tdata),
    .data_tvalid    (data_tvalid),
    .data_tready    (data_tready),
    .data_tlast     (data_tlast),
    .data_tuser     (data_tuser),
    .payload_length (payload_length),
    .pkt_count      (pkt_count)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clk_enable = 1'b0; pkt_sent = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; clk_enable = 1'b1; data_tready = 1'b1;
    model_s = 7'h7F;
  endtask

  task automatic pulse_sent();
    @(negedge clk); pkt_sent = 1'b1;
    @(negedge clk); pkt_sent = 1'b0;
  endtask

  // Records beats until tlast, until stop_at beats, or until max_cyc cycles pass.
  task automatic collect(input bit rnd, input int stop_at, input int max_cyc);
    bit prev_hold; bit done;
    logic [7:0] prev_dat; logic prev_last, prev_user;
    bits_q.delete();
    nbeats = 0; last_idx = -1; nlast = 0; user_ones = 0; user_zeros = 0;
    stall_err = 0; hi_err = 0; timed_out = 1'b1;
    prev_hold = 1'b0; done = 1'b0;
    prev_dat = '0; prev_last = 1'b0; prev_user = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk);
      if (rnd) begin
        clk_enable  = ($urandom_range(0, 3) != 0);
        data_tready = ($urandom_range(0, 2) != 0);
      end else begin
        clk_enable = 1'b1; data_tready = 1'b1;
      end
      if (prev_hold && (data_tvalid !== 1'b1 || data_tdata !== prev_dat ||
                        data_tlast !== prev_last || data_tuser !== prev_user))
        stall_err++;
      if (clk_enable && data_tvalid === 1'b1 && data_tready) begin
        if (data_tdata[7:2] !== 6'd0 || (data_tuser && data_tdata[1] !== 1'b0)) hi_err++;
        bits_q.push_back(data_tdata[0]);
        if (!data_tuser) bits_q.push_back(data_tdata[1]);
        if (data_tuser) user_ones++; else user_zeros++;
        if (data_tlast) begin
          nlast++;
          if (last_idx < 0) last_idx = nbeats;
          done = 1'b1; timed_out = 1'b0;
        end
        nbeats++;
        if (nbeats == stop_at) begin done = 1'b1; timed_out = 1'b0; end
        prev_hold = 1'b0;
      end else begin
        prev_hold = (data_tvalid === 1'b1);
      end
      prev_dat = data_tdata; prev_last = data_tlast; prev_user = data_tuser;
    end
    clk_enable = 1'b1; data_tready = 1'b1;
  endtask

  // Compares captured bits against the reference register, advancing it.
  task automatic model_errs(output int errs);
    bit fb;
    errs = 0;
    foreach (bits_q[i]) begin
      fb = model_s[6] ^ model_s[5];
      model_s = {model_s[5:0], fb};
      if (bits_q[i] !== fb) errs++;
    end
  endtask

  task automatic test_reset();
    int vld_seen;
    MODE_CTRL = 4'd0; len_cfg = 16'd0;
    do_reset();
    checks++; if (data_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", data_tvalid); end
    checks++; if (data_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", data_tlast); end
    checks++; if (data_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser got %b want 0", data_tuser); end
    checks++; if (data_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h want 00", data_tdata); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count got %0d want 0", pkt_count); end
    checks++; if (payload_length !== 16'd0) begin errors++; $display("FAIL reset_payload_length got %0d want 0", payload_length); end
    // Undefined mode plus a stray pkt_sent must leave the source idle.
    vld_seen = 0;
    pkt_sent = 1'b1;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (data_tvalid !== 1'b0) vld_seen++; end
    pkt_sent = 1'b0;
    checks++; if (vld_seen !== 0) begin errors++; $display("FAIL idle_off_mode got %0d valid cycles want 0", vld_seen); end
  endtask

  task automatic test_bpsk();
    int errs, vld_seen; logic [7:0] first8;
    MODE_CTRL = MODE_BPSK; len_cfg = 16'd128;
    do_reset();
    collect(1'b0, -1, 400);
    model_errs(errs);
    first8 = '0;
    for (int i = 0; i < 8 && i < bits_q.size(); i++) first8[i] = bits_q[i];
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL bpsk_timeout got %b want 0", timed_out); end
    checks++; if (nbeats !== 132) begin errors++; $display("FAIL bpsk_beats got %0d want 132", nbeats); end
    checks++; if (last_idx !== 131 || nlast !== 1) begin errors++; $display("FAIL bpsk_tlast got idx %0d cnt %0d want 131/1", last_idx, nlast); end
    checks++; if (user_ones !== 132) begin errors++; $display("FAIL bpsk_tuser got %0d ones want 132", user_ones); end
    checks++; if (first8 !== 8'b0100_0000) begin errors++; $display("FAIL bpsk_first8 got %b want 01000000", first8); end
    checks++; if (errs !== 0) begin errors++; $display("FAIL bpsk_pn got %0d bit errors want 0", errs); end
    checks++; if (hi_err !== 0) begin errors++; $display("FAIL bpsk_upper_bits got %0d want 0", hi_err); end
    // Sitting in WAIT_SENT: new configuration must not leak into the status or the output.
    MODE_CTRL = MODE_QPSK; len_cfg = 16'd10;
    vld_seen = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (data_tvalid !== 1'b0) vld_seen++; end
    checks++; if (vld_seen !== 0) begin errors++; $display("FAIL bpsk_wait_valid got %0d want 0", vld_seen); end
    checks++; if (payload_length !== 16'd128) begin errors++; $display("FAIL bpsk_payload got %0d want 128", payload_length); end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL bpsk_pkt_count got %0d want 1", pkt_count); end
    pulse_sent();
    collect(1'b0, -1, 100);
    model_errs(errs);
    checks++; if (nbeats !== 9 || user_zeros !== 9) begin errors++; $display("FAIL next_cfg_beats got %0d/%0d want 9/9", nbeats, user_zeros); end
    checks++; if (errs !== 0) begin errors++; $display("FAIL next_cfg_pn got %0d want 0", errs); end
    checks++; if (payload_length !== 16'd10) begin errors++; $display("FAIL next_cfg_payload got %0d want 10", payload_length); end
  endtask

  task automatic test_qpsk();
    int errs;
    MODE_CTRL = MODE_QPSK; len_cfg = 16'd129;
    do_reset();
    collect(1'b0, -1, 300);
    model_errs(errs);
    checks++; if (nbeats !== 69 || last_idx !== 68) begin errors++; $display("FAIL qpsk_beats got %0d last %0d want 69/68", nbeats, last_idx); end
    checks++; if (user_zeros !== 69) begin errors++; $display("FAIL qpsk_tuser got %0d zeros want 69", user_zeros); end
    checks++; if (bits_q.size() !== 138 || errs !== 0) begin errors++; $display("FAIL qpsk_pn got %0d bits %0d errs want 138/0", bits_q.size(), errs); end
    checks++; if (payload_length !== 16'd129) begin errors++; $display("FAIL qpsk_payload got %0d want 129", payload_length); end
  endtask

  task automatic test_mix();
    int errs, vld_seen;
    int exp_beats[3] = '{68, 132, 68};
    int exp_ones[3]  = '{0, 132, 0};
    MODE_CTRL = MODE_MIX; len_cfg = 16'd128;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      collect(1'b0, -1, 400);
      model_errs(errs);
      checks++; if (nbeats !== exp_beats[p]) begin errors++; $display("FAIL mix_beats pkt %0d got %0d want %0d", p, nbeats, exp_beats[p]); end
      checks++; if (user_ones !== exp_ones[p]) begin errors++; $display("FAIL mix_tuser pkt %0d got %0d ones want %0d", p, user_ones, exp_ones[p]); end
      checks++; if (errs !== 0) begin errors++; $display("FAIL mix_pn pkt %0d got %0d errs want 0", p, errs); end
      if (p == 2) MODE_CTRL = 4'b1000;
      pulse_sent();
    end
    vld_seen = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (data_tvalid !== 1'b0) vld_seen++; end
    checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL mix_pkt_count got %0d want 3", pkt_count); end
    checks++; if (vld_seen !== 0) begin errors++; $display("FAIL mix_to_idle got %0d valid cycles want 0", vld_seen); end
  endtask

  task automatic test_stall();
    int errs;
    MODE_CTRL = MODE_QPSK; len_cfg = 16'd129;
    do_reset();
    collect(1'b1, -1, 2000);
    model_errs(errs);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL stall_timeout got %b want 0", timed_out); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL stall_hold got %0d changes want 0", stall_err); end
    checks++; if (nbeats !== 69 || last_idx !== 68) begin errors++; $display("FAIL stall_beats got %0d last %0d want 69/68", nbeats, last_idx); end
    checks++; if (errs !== 0) begin errors++; $display("FAIL stall_pn got %0d errs want 0", errs); end
  endtask

  task automatic test_len_clamp();
    int errs;
    MODE_CTRL = MODE_BPSK; len_cfg = 16'd0;
    do_reset();
    collect(1'b0, -1, 100);
    model_errs(errs);
    checks++; if (nbeats !== 5) begin errors++; $display("FAIL len0_beats got %0d want 5", nbeats); end
    checks++; if (payload_length !== 16'd1) begin errors++; $display("FAIL len0_payload got %0d want 1", payload_length); end
    len_cfg = 16'd4000;
    pulse_sent();
    collect(1'b0, -1, 3000);
    model_errs(errs);
    checks++; if (nbeats !== 2052) begin errors++; $display("FAIL lenmax_beats got %0d want 2052", nbeats); end
    checks++; if (payload_length !== 16'd2048) begin errors++; $display("FAIL lenmax_payload got %0d want 2048", payload_length); end
    checks++; if (errs !== 0) begin errors++; $display("FAIL lenmax_pn got %0d errs want 0", errs); end
  endtask

  task automatic test_reset_mid();
    int errs;
    MODE_CTRL = MODE_BPSK; len_cfg = 16'd128;
    do_reset();
    collect(1'b0, 50, 200);
    checks++; if (nbeats !== 50 || nlast !== 0) begin errors++; $display("FAIL midrst_pre got %0d beats %0d tlast want 50/0", nbeats, nlast); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if (data_tvalid !== 1'b0 || data_tlast !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got v%b l%b want 0/0", data_tvalid, data_tlast); end
    checks++; if (data_tdata !== 8'h00 || data_tuser !== 1'b0) begin errors++; $display("FAIL midrst_data got %h u%b want 00/0", data_tdata, data_tuser); end
    checks++; if (pkt_count !== 16'd0 || payload_length !== 16'd0) begin errors++; $display("FAIL midrst_status got %0d/%0d want 0/0", pkt_count, payload_length); end
    rst = 1'b0; model_s = 7'h7F;
    collect(1'b0, -1, 400);
    model_errs(errs);
    checks++; if (nbeats !== 132 || last_idx !== 131) begin errors++; $display("FAIL midrst_restart got %0d last %0d want 132/131", nbeats, last_idx); end
    checks++; if (errs !== 0) begin errors++; $display("FAIL midrst_pn got %0d errs want 0", errs); end
  endtask

  initial begin
    model_s = 7'h7F;
    test_reset();
    test_bpsk();
    test_qpsk();
    test_mix();
    test_stall();
    test_len_clamp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_data_src.md
PKT_DATA_SRC -- requirements
Module: pkt_data_src

Interface
REQ-001 SHALL have parameter BYTES, default 1, tdata width in bytes (minimum 1).
REQ-002 SHALL have parameter LFSR_N, default 7, PN register length (range 3..16).
REQ-003 SHALL have parameter LFSR_TAPS, default 16'h0060, feedback tap mask (bit i = stage i+1).
REQ-004 SHALL have parameter PAD_SYMBS, default 4, extra symbols appended to every packet.
REQ-005 SHALL have parameter MAX_LEN, default 16'd2048, payload length ceiling in bits.
REQ-006 SHALL have port clk  input  1  system clock; one clock; reset is synchronous and active-high.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port clk_enable  input  1  symbol-rate qualifier.
REQ-009 SHALL have port MODE_CTRL  input  4  0001 BPSK, 0010 QPSK, 0100 MIX, other = off.
REQ-010 SHALL have port len_cfg  input  16  requested payload length in bits.
REQ-011 SHALL have port pkt_sent  input  1  packetizer done pulse.
REQ-012 SHALL have ports data_tdata (output, BYTES*8), data_tvalid (output, 1), data_tready (input, 1), data_tlast (output, 1): AXIS source.
REQ-013 SHALL have port data_tuser  output  1  1 = BPSK symbol, 0 = QPSK symbol.
REQ-014 SHALL have ports payload_length (output, 16), latched length of current packet; pkt_count (output, 16), packets fully emitted.

Function
REQ-015 SHALL advance state, counters, and LFSR only in cycles with clk_enable=1; with clk_enable=0, all registers hold.
REQ-016 SHALL count a transfer ("beat") only when clk_enable & data_tvalid & data_tready.
REQ-017 SHALL hold tdata/tlast/tuser stable while tvalid=1 and no beat has occurred (AXIS rule).
REQ-018 SHALL implement FSM IDLE -> LOAD -> SEND -> WAIT_SENT -> LOAD.
REQ-019 IDLE: tvalid=0; go to LOAD when MODE_CTRL is a defined mode.
REQ-020 LOAD (one enabled cycle): latch mode and len = clamp(len_cfg, 1, MAX_LEN) into payload_length; MIX toggles the per-packet BPSK flag (first MIX packet is QPSK); compute nsym = len (BPSK) or (len+1)>>1 (QPSK), plus PAD_SYMBS.
REQ-021 SEND: tvalid=1; symbol counter increments per beat; tlast=1 exactly on beat index nsym-1; after the tlast beat, go to WAIT_SENT and increment pkt_count (wraps at 16'hFFFF).
REQ-022 WAIT_SENT: tvalid=0; on pkt_sent go to LOAD, or to IDLE if MODE_CTRL is undefined.
REQ-023 pkt_sent in IDLE/LOAD/SEND SHALL be ignored.
REQ-024 MODE_CTRL/len_cfg changes during SEND/WAIT_SENT SHALL take effect only at the next LOAD.
REQ-025 tdata[0] = first PN bit; in QPSK, tdata[1] = second PN bit; bits above SHALL be 0; BPSK tdata[1] = 0.
REQ-026 On each beat, LFSR SHALL step 1 (BPSK) or 2 (QPSK) times, so the packet bit stream is the contiguous PN sequence.
REQ-027 tuser SHALL equal the latched BPSK flag for every beat of a packet.
REQ-028 All length/counter arithmetic SHALL be 16-bit unsigned with no overflow for MAX_LEN+PAD_SYMBS <= 16'hFFFF.

Reset
REQ-029 On rst=1 (regardless of clk_enable): state IDLE, tvalid/tlast/tuser=0, tdata=0, counters=0, pkt_count=0, payload_length=0, MIX flag=0, LFSR = all ones.
REQ-030 Reset mid-packet SHALL abort without emitting tlast; the next packet starts from LFSR all ones.

Structure
REQ-031 Mode codes, FSM state encoding, and LFSR reset seed SHALL live in shared package pkt_data_pkg.
REQ-032 LFSR stepping SHALL be a sub-module pn_lfsr_step (combinational 1-/2-step next-state from LFSR_N, LFSR_TAPS) instantiated once.
REQ-033 Implementation SHALL target 120-400 lines of RTL.

Verification
REQ-034 BPSK, len_cfg=128, tready=1, clk_enable=1 -> 132 beats, tlast only on beat 131, tuser=1, then tvalid=0 until pkt_sent.
REQ-035 QPSK, len_cfg=129 -> 65+4=69 beats, tuser=0, 138 PN bits contiguous vs software model.
REQ-036 MIX, len_cfg=128, pkt_sent after each tlast -> packets of 68, 132, 68 beats; tuser 0,1,0; pkt_count 3.
REQ-037 Random tready and clk_enable toggling -> tdata/tlast stable while stalled; bit stream identical to REQ-035.
REQ-038 len_cfg=0 -> payload_length=1, 5 beats; len_cfg=4000 -> payload_length=2048.
REQ-039 rst asserted at beat 50 of a packet -> all outputs 0 next cycle, no tlast; restart reproduces first packet bit-exactly.
